// File: rtl/id_issue_stage.sv
// RV32I integer decode/issue stage: decodes OP-IMM, OP, LUI and AUIPC, resolves operands through
// prioritised forwarding, stalls on load-use hazards and registers the result behind a valid/ready handshake.
module id_issue_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    inValid_in,
  output logic                    inReady_out,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [31:0]             inst_in,
  output logic                    reg1E_out,
  output logic                    reg2E_out,
  output logic [4:0]              reg1Idx_out,
  output logic [4:0]              reg2Idx_out,
  input  logic [XLEN-1:0]         reg1Data_in,
  input  logic [XLEN-1:0]         reg2Data_in,
  input  logic [NUM_FWD-1:0]      fwdRdE_in,
  input  logic [5*NUM_FWD-1:0]    fwdRdIdx_in,
  input  logic [XLEN*NUM_FWD-1:0] fwdRdData_in,
  input  logic                    exLoad_in,
  input  logic [4:0]              exLoadIdx_in,
  output logic                    outValid_out,
  input  logic                    outReady_in,
  output logic [XLEN-1:0]         pc_out,
  output logic                    instValid_out,
  output logic [3:0]              instIdx_out,
  output logic [1:0]              instType_out,
  output logic                    rdE_out,
  output logic [4:0]              rdIdx_out,
  output logic [XLEN-1:0]         rs1Data_out,
  output logic [XLEN-1:0]         rs2Data_out,
  output logic [XLEN-1:0]         imm_out,
  output logic [CNT_W-1:0]        stallCnt_out
);

  localparam logic [3:0] ID_NOP  = 4'd0;
  localparam logic [3:0] ID_ADD  = 4'd1;
  localparam logic [3:0] ID_SUB  = 4'd2;
  localparam logic [3:0] ID_SLL  = 4'd3;
  localparam logic [3:0] ID_SLT  = 4'd4;
  localparam logic [3:0] ID_SLTU = 4'd5;
  localparam logic [3:0] ID_XOR  = 4'd6;
  localparam logic [3:0] ID_SRL  = 4'd7;
  localparam logic [3:0] ID_SRA  = 4'd8;
  localparam logic [3:0] ID_OR   = 4'd9;
  localparam logic [3:0] ID_AND  = 4'd10;
  localparam logic [1:0] TYPE_NOP = 2'd0;
  localparam logic [1:0] TYPE_ALU = 2'd1;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  assign opcode = inst_in[6:0];
  assign rd_f   = inst_in[11:7];
  assign funct3 = inst_in[14:12];
  assign rs1_f  = inst_in[19:15];
  assign rs2_f  = inst_in[24:20];
  assign funct7 = inst_in[31:25];

  logic            dec_valid, dec_r1e, dec_r2e, dec_rde, is_lui, is_auipc;
  logic [3:0]      dec_idx;
  logic [1:0]      dec_type;
  logic [XLEN-1:0] dec_imm, op1, op2, rs1_val, rs2_val;
  logic            hazard, can_load;

  logic            out_valid_q, out_valid_d, inst_valid_q, inst_valid_d, rd_e_q, rd_e_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [3:0]      inst_idx_q, inst_idx_d;
  logic [1:0]      inst_type_q, inst_type_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Youngest matching forwarding source wins; x0 is hard-wired to zero.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]              idx,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      fe,
    input logic [5*NUM_FWD-1:0]    fi,
    input logic [XLEN*NUM_FWD-1:0] fd
  );
    logic [XLEN-1:0] v;
    v = rf;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      v = (fe[j] && (fi[5*j +: 5] == idx)) ? fd[XLEN*j +: XLEN] : v;
    end
    return (idx == 5'd0) ? {XLEN{1'b0}} : v;
  endfunction

  always_comb begin
    dec_valid = 1'b0;
    dec_idx   = ID_NOP;
    dec_type  = TYPE_NOP;
    dec_r1e   = 1'b0;
    dec_r2e   = 1'b0;
    dec_rde   = 1'b0;
    dec_imm   = {XLEN{1'b0}};
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        dec_valid = 1'b1;
        dec_r1e   = 1'b1;
        dec_imm   = {{(XLEN-12){inst_in[31]}}, inst_in[31:20]};
        case (funct3)
          3'b000: dec_idx = ID_ADD;
          3'b010: dec_idx = ID_SLT;
          3'b011: dec_idx = ID_SLTU;
          3'b100: dec_idx = ID_XOR;
          3'b110: dec_idx = ID_OR;
          3'b111: dec_idx = ID_AND;
          3'b001: begin
            dec_imm = {{(XLEN-5){1'b0}}, inst_in[24:20]};
            if (funct7 == 7'h00) dec_idx = ID_SLL;
            else                 dec_valid = 1'b0;
          end
          3'b101: begin
            dec_imm = {{(XLEN-5){1'b0}}, inst_in[24:20]};
            if (funct7 == 7'h00)      dec_idx = ID_SRL;
            else if (funct7 == 7'h20) dec_idx = ID_SRA;
            else                      dec_valid = 1'b0;
          end
          default: dec_valid = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec_valid = 1'b1;
        dec_r1e   = 1'b1;
        dec_r2e   = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  dec_idx = ID_ADD;
            3'b001:  dec_idx = ID_SLL;
            3'b010:  dec_idx = ID_SLT;
            3'b011:  dec_idx = ID_SLTU;
            3'b100:  dec_idx = ID_XOR;
            3'b101:  dec_idx = ID_SRL;
            3'b110:  dec_idx = ID_OR;
            3'b111:  dec_idx = ID_AND;
            default: dec_valid = 1'b0;
          endcase
        end else if (funct7 == 7'h20) begin
          case (funct3)
            3'b000:  dec_idx = ID_SUB;
            3'b101:  dec_idx = ID_SRA;
            default: dec_valid = 1'b0;
          endcase
        end else begin
          dec_valid = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_valid = 1'b1;
        dec_idx   = ID_ADD;
        dec_imm   = {inst_in[31:12], 12'b0};
        is_lui    = (opcode == OPC_LUI);
        is_auipc  = (opcode == OPC_AUIPC);
      end
      default: dec_valid = 1'b0;
    endcase
    // Unsupported encodings must not read, write or stall anything.
    if (dec_valid) begin
      dec_type = TYPE_ALU;
      dec_rde  = (rd_f != 5'd0);
    end else begin
      dec_idx  = ID_NOP;
      dec_r1e  = 1'b0;
      dec_r2e  = 1'b0;
      dec_imm  = {XLEN{1'b0}};
      is_lui   = 1'b0;
      is_auipc = 1'b0;
    end
  end

  always_comb begin
    op1 = resolve(rs1_f, reg1Data_in, fwdRdE_in, fwdRdIdx_in, fwdRdData_in);
    op2 = resolve(rs2_f, reg2Data_in, fwdRdE_in, fwdRdIdx_in, fwdRdData_in);
    if (is_auipc)     rs1_val = pc_in;
    else if (dec_r1e) rs1_val = op1;
    else              rs1_val = {XLEN{1'b0}};
    rs2_val = dec_r2e ? op2 : dec_imm;
  end

  assign hazard = inValid_in && exLoad_in && (exLoadIdx_in != 5'd0) &&
                  ((dec_r1e && (rs1_f == exLoadIdx_in)) || (dec_r2e && (rs2_f == exLoadIdx_in)));
  assign can_load    = !out_valid_q || outReady_in;
  assign inReady_out = flush_in || (can_load && !hazard);
  assign reg1E_out   = dec_r1e;
  assign reg2E_out   = dec_r2e;
  assign reg1Idx_out = rs1_f;
  assign reg2Idx_out = rs2_f;

  always_comb begin
    out_valid_d  = out_valid_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_idx_d   = inst_idx_q;
    inst_type_d  = inst_type_q;
    rd_e_d       = rd_e_q;
    rd_idx_d     = rd_idx_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    if (flush_in) begin
      out_valid_d = 1'b0;
    end else if (can_load && inValid_in && !hazard) begin
      out_valid_d  = 1'b1;
      pc_d         = pc_in;
      inst_valid_d = dec_valid;
      inst_idx_d   = dec_idx;
      inst_type_d  = dec_type;
      rd_e_d       = dec_rde;
      rd_idx_d     = rd_f;
      rs1_d        = rs1_val;
      rs2_d        = rs2_val;
      imm_d        = dec_imm;
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (hazard && !flush_in && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_q  <= 1'b0;
      pc_q         <= {XLEN{1'b0}};
      inst_valid_q <= 1'b0;
      inst_idx_q   <= ID_NOP;
      inst_type_q  <= TYPE_NOP;
      rd_e_q       <= 1'b0;
      rd_idx_q     <= 5'd0;
      rs1_q        <= {XLEN{1'b0}};
      rs2_q        <= {XLEN{1'b0}};
      imm_q        <= {XLEN{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_idx_q   <= inst_idx_d;
      inst_type_q  <= inst_type_d;
      rd_e_q       <= rd_e_d;
      rd_idx_q     <= rd_idx_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign outValid_out  = out_valid_q;
  assign pc_out        = pc_q;
  assign instValid_out = inst_valid_q;
  assign instIdx_out   = inst_idx_q;
  assign instType_out  = inst_type_q;
  assign rdE_out       = rd_e_q;
  assign rdIdx_out     = rd_idx_q;
  assign rs1Data_out   = rs1_q;
  assign rs2Data_out   = rs2_q;
  assign imm_out       = imm_q;
  assign stallCnt_out  = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: decode, forwarding priority, load-use stall, back-pressure,
// flush, stall-counter saturation and asynchronous reset.
module tb_id_issue_stage;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, inValid_in, inReady_out;
  logic [31:0] pc_in, inst_in;
  logic        reg1E_out, reg2E_out;
  logic [4:0]  reg1Idx_out, reg2Idx_out;
  logic [31:0] reg1Data_in, reg2Data_in;
  logic [1:0]  fwdRdE_in;
  logic [9:0]  fwdRdIdx_in;
  logic [63:0] fwdRdData_in;
  logic        exLoad_in;
  logic [4:0]  exLoadIdx_in;
  logic        outValid_out, outReady_in;
  logic [31:0] pc_out;
  logic        instValid_out;
  logic [3:0]  instIdx_out;
  logic [1:0]  instType_out;
  logic        rdE_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rs1Data_out, rs2Data_out, imm_out;
  logic [15:0] stallCnt_out;

  int tests_run = 0;
  int tests_failed = 0;

  id_issue_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .inValid_in(inValid_in), .inReady_out(inReady_out),
    .pc_in(pc_in), .inst_in(inst_in),
    .reg1E_out(reg1E_out), .reg2E_out(reg2E_out),
    .reg1Idx_out(reg1Idx_out), .reg2Idx_out(reg2Idx_out),
    .reg1Data_in(reg1Data_in), .reg2Data_in(reg2Data_in),
    .fwdRdE_in(fwdRdE_in), .fwdRdIdx_in(fwdRdIdx_in), .fwdRdData_in(fwdRdData_in),
    .exLoad_in(exLoad_in), .exLoadIdx_in(exLoadIdx_in),
    .outValid_out(outValid_out), .outReady_in(outReady_in),
    .pc_out(pc_out), .instValid_out(instValid_out),
    .instIdx_out(instIdx_out), .instType_out(instType_out),
    .rdE_out(rdE_out), .rdIdx_out(rdIdx_out),
    .rs1Data_out(rs1Data_out), .rs2Data_out(rs2Data_out),
    .imm_out(imm_out), .stallCnt_out(stallCnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; flush_in = 1'b0; inValid_in = 1'b0; outReady_in = 1'b1;
    pc_in = 32'h0; inst_in = 32'h0; reg1Data_in = 32'h0; reg2Data_in = 32'h0;
    fwdRdE_in = 2'b00; fwdRdIdx_in = 10'h0; fwdRdData_in = 64'h0;
    exLoad_in = 1'b0; exLoadIdx_in = 5'd0;
    tick(); tick();
    tests_run++; if (outValid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_outValid got=%0h exp=0", outValid_out); end
    tests_run++; if (instIdx_out !== 4'd0 || instType_out !== 2'd0) begin tests_failed++; $display("FAIL reset_nop got=%0h/%0h exp=0/0", instIdx_out, instType_out); end
    tests_run++; if (stallCnt_out !== 16'd0 || pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt_pc got=%0h/%0h exp=0/0", stallCnt_out, pc_out); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    inst_in = 32'hFFF00293; pc_in = 32'h40; inValid_in = 1'b1; outReady_in = 1'b1; reg1Data_in = 32'h55;
    tick();
    tests_run++; if (outValid_out !== 1'b1 || instValid_out !== 1'b1) begin tests_failed++; $display("FAIL addi_valid got=%0h/%0h exp=1/1", outValid_out, instValid_out); end
    tests_run++; if (instIdx_out !== 4'd1 || instType_out !== 2'd1) begin tests_failed++; $display("FAIL addi_idx got=%0h/%0h exp=1/1", instIdx_out, instType_out); end
    tests_run++; if (rdE_out !== 1'b1 || rdIdx_out !== 5'd5) begin tests_failed++; $display("FAIL addi_rd got=%0h/%0d exp=1/5", rdE_out, rdIdx_out); end
    tests_run++; if (rs1Data_out !== 32'h0 || rs2Data_out !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL addi_ops got=%h/%h exp=0/ffffffff", rs1Data_out, rs2Data_out); end
    tests_run++; if (pc_out !== 32'h40 || imm_out !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL addi_pc_imm got=%h/%h exp=40/ffffffff", pc_out, imm_out); end
  endtask

  task automatic test_forwarding();
    inst_in = 32'h002081B3; reg1Data_in = 32'd10; reg2Data_in = 32'd20;
    fwdRdE_in = 2'b11; fwdRdIdx_in = {5'd1, 5'd1}; fwdRdData_in = {32'd9, 32'd7};
    #1;
    tests_run++; if (reg1E_out !== 1'b1 || reg2E_out !== 1'b1 || reg1Idx_out !== 5'd1 || reg2Idx_out !== 5'd2) begin tests_failed++; $display("FAIL fwd_rfport got=%0h%0h/%0d/%0d exp=11/1/2", reg1E_out, reg2E_out, reg1Idx_out, reg2Idx_out); end
    tick();
    tests_run++; if (rs1Data_out !== 32'd7 || rs2Data_out !== 32'd20) begin tests_failed++; $display("FAIL fwd_priority got=%0d/%0d exp=7/20", rs1Data_out, rs2Data_out); end
    fwdRdIdx_in = {5'd2, 5'd1}; fwdRdData_in = {32'd4, 32'd7};
    tick();
    tests_run++; if (rs1Data_out !== 32'd7 || rs2Data_out !== 32'd4) begin tests_failed++; $display("FAIL fwd_both got=%0d/%0d exp=7/4", rs1Data_out, rs2Data_out); end
    fwdRdE_in = 2'b00;
    tick();
    tests_run++; if (rs1Data_out !== 32'd10 || rs2Data_out !== 32'd20) begin tests_failed++; $display("FAIL fwd_none got=%0d/%0d exp=10/20", rs1Data_out, rs2Data_out); end
  endtask

  task automatic test_load_use();
    inst_in = 32'h402081B3; exLoad_in = 1'b1; exLoadIdx_in = 5'd1; inValid_in = 1'b1; outReady_in = 1'b1;
    #1;
    tests_run++; if (inReady_out !== 1'b0) begin tests_failed++; $display("FAIL lu_ready_rs1 got=%0h exp=0", inReady_out); end
    exLoadIdx_in = 5'd2; #1;
    tests_run++; if (inReady_out !== 1'b0) begin tests_failed++; $display("FAIL lu_ready_rs2 got=%0h exp=0", inReady_out); end
    exLoadIdx_in = 5'd3; #1;
    tests_run++; if (inReady_out !== 1'b1) begin tests_failed++; $display("FAIL lu_ready_rd got=%0h exp=1", inReady_out); end
    exLoadIdx_in = 5'd1;
    tick();
    tests_run++; if (outValid_out !== 1'b0 || stallCnt_out !== 16'd1) begin tests_failed++; $display("FAIL lu_stall got=%0h/%0d exp=0/1", outValid_out, stallCnt_out); end
    exLoad_in = 1'b0; #1;
    tests_run++; if (inReady_out !== 1'b1) begin tests_failed++; $display("FAIL lu_release got=%0h exp=1", inReady_out); end
    tick();
    tests_run++; if (outValid_out !== 1'b1 || instIdx_out !== 4'd2 || rs1Data_out !== 32'd10 || rs2Data_out !== 32'd20) begin tests_failed++; $display("FAIL lu_capture got=%0h/%0h/%0d/%0d exp=1/2/10/20", outValid_out, instIdx_out, rs1Data_out, rs2Data_out); end
    tests_run++; if (stallCnt_out !== 16'd1) begin tests_failed++; $display("FAIL lu_cnt_hold got=%0d exp=1", stallCnt_out); end
  endtask

  task automatic test_back_to_back();
    outReady_in = 1'b0; inst_in = 32'h00500313; inValid_in = 1'b1;
    #1;
    tests_run++; if (inReady_out !== 1'b0) begin tests_failed++; $display("FAIL bp_ready got=%0h exp=0", inReady_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (outValid_out !== 1'b1 || instIdx_out !== 4'd2 || rdIdx_out !== 5'd3) begin tests_failed++; $display("FAIL bp_hold%0d got=%0h/%0h/%0d exp=1/2/3", i, outValid_out, instIdx_out, rdIdx_out); end
    end
    outReady_in = 1'b1; #1;
    tests_run++; if (inReady_out !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_rel got=%0h exp=1", inReady_out); end
    tick();
    tests_run++; if (instIdx_out !== 4'd1 || rdIdx_out !== 5'd6 || rs2Data_out !== 32'd5) begin tests_failed++; $display("FAIL bp_next got=%0h/%0d/%0d exp=1/6/5", instIdx_out, rdIdx_out, rs2Data_out); end
  endtask

  task automatic test_flush();
    flush_in = 1'b1; outReady_in = 1'b0; inValid_in = 1'b1; inst_in = 32'h002081B3;
    exLoad_in = 1'b1; exLoadIdx_in = 5'd1;
    #1;
    tests_run++; if (inReady_out !== 1'b1) begin tests_failed++; $display("FAIL fl_ready got=%0h exp=1", inReady_out); end
    tick();
    tests_run++; if (outValid_out !== 1'b0 || stallCnt_out !== 16'd1) begin tests_failed++; $display("FAIL fl_kill got=%0h/%0d exp=0/1", outValid_out, stallCnt_out); end
    flush_in = 1'b0; exLoad_in = 1'b0; inValid_in = 1'b0; outReady_in = 1'b1;
    tick();
    tests_run++; if (outValid_out !== 1'b0) begin tests_failed++; $display("FAIL fl_nocapture got=%0h exp=0", outValid_out); end
  endtask

  task automatic test_saturation();
    inst_in = 32'h402081B3; exLoad_in = 1'b1; exLoadIdx_in = 5'd1; inValid_in = 1'b1; outReady_in = 1'b1;
    for (int i = 0; i < 65533; i++) @(posedge clk_in);
    #1;
    tests_run++; if (stallCnt_out !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_pre got=%h exp=fffe", stallCnt_out); end
    tick();
    tests_run++; if (stallCnt_out !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_max got=%h exp=ffff", stallCnt_out); end
    for (int i = 0; i < 4; i++) @(posedge clk_in);
    #1;
    tests_run++; if (stallCnt_out !== 16'hFFFF || outValid_out !== 1'b0) begin tests_failed++; $display("FAIL sat_hold got=%h/%0h exp=ffff/0", stallCnt_out, outValid_out); end
    exLoad_in = 1'b0;
  endtask

  task automatic test_decode();
    inValid_in = 1'b1; outReady_in = 1'b1; exLoad_in = 1'b1; exLoadIdx_in = 5'd1;
    inst_in = 32'h022081B3; #1;
    tests_run++; if (inReady_out !== 1'b1 || reg1E_out !== 1'b0) begin tests_failed++; $display("FAIL dec_bad_nohaz got=%0h/%0h exp=1/0", inReady_out, reg1E_out); end
    tick();
    tests_run++; if (outValid_out !== 1'b1 || instValid_out !== 1'b0 || rdE_out !== 1'b0 || instIdx_out !== 4'd0) begin tests_failed++; $display("FAIL dec_bad_f7 got=%0h/%0h/%0h/%0h exp=1/0/0/0", outValid_out, instValid_out, rdE_out, instIdx_out); end
    exLoad_in = 1'b0; inst_in = 32'h0000007F;
    tick();
    tests_run++; if (instValid_out !== 1'b0 || rdE_out !== 1'b0 || instType_out !== 2'd0) begin tests_failed++; $display("FAIL dec_bad_opc got=%0h/%0h/%0h exp=0/0/0", instValid_out, rdE_out, instType_out); end
    inst_in = 32'h00001397; pc_in = 32'h100;
    tick();
    tests_run++; if (rs1Data_out !== 32'h100 || rs2Data_out !== 32'h1000 || rdIdx_out !== 5'd7 || instIdx_out !== 4'd1) begin tests_failed++; $display("FAIL dec_auipc got=%h/%h/%0d/%0h exp=100/1000/7/1", rs1Data_out, rs2Data_out, rdIdx_out, instIdx_out); end
    inst_in = 32'hABCDE437;
    tick();
    tests_run++; if (rs1Data_out !== 32'h0 || rs2Data_out !== 32'hABCDE000 || rdIdx_out !== 5'd8) begin tests_failed++; $display("FAIL dec_lui got=%h/%h/%0d exp=0/abcde000/8", rs1Data_out, rs2Data_out, rdIdx_out); end
    inst_in = 32'h4030D493;
    tick();
    tests_run++; if (instIdx_out !== 4'd8 || rs1Data_out !== 32'd10 || rs2Data_out !== 32'd3 || rdIdx_out !== 5'd9) begin tests_failed++; $display("FAIL dec_srai got=%0h/%0d/%0d/%0d exp=8/10/3/9", instIdx_out, rs1Data_out, rs2Data_out, rdIdx_out); end
    inst_in = 32'h00108013;
    tick();
    tests_run++; if (rdE_out !== 1'b0 || instValid_out !== 1'b1 || rs1Data_out !== 32'd10 || rs2Data_out !== 32'd1) begin tests_failed++; $display("FAIL dec_rd0 got=%0h/%0h/%0d/%0d exp=0/1/10/1", rdE_out, instValid_out, rs1Data_out, rs2Data_out); end
  endtask

  task automatic test_async_reset();
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    tests_run++; if (outValid_out !== 1'b0 || instIdx_out !== 4'd0 || stallCnt_out !== 16'd0) begin tests_failed++; $display("FAIL areset got=%0h/%0h/%0d exp=0/0/0", outValid_out, instIdx_out, stallCnt_out); end
    inValid_in = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    tests_run++; if (outValid_out !== 1'b0) begin tests_failed++; $display("FAIL areset_after got=%0h exp=0", outValid_out); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forwarding();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_decode();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
